// File: rtl/nios_pio_pulse_out.sv
// rtl/nios_pio_pulse_out.sv - Avalon-MM PIO output port with auto-clearing pulse timer
// Masked DATA bits set by a DATA/OUTSET write are cleared after PULSE_LEN cycles.
module nios_pio_pulse_out #(
  parameter int               WIDTH             = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
  parameter int               DEFAULT_PULSE_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] data, data_wr, data_next;
  logic [WIDTH-1:0] mask;
  logic [15:0]      plen;
  logic [15:0]      cnt, cnt_next;
  logic [WIDTH-1:0] wd;
  logic             wr_en;
  logic             trigger;
  logic             unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign unused_bits = ^writedata[31:16];

  // DATA as it would look after this cycle's host write alone
  always_comb begin
    data_wr = data;
    if (wr_en) begin
      case (address)
        3'd0:    data_wr = wd;
        3'd2:    data_wr = data | wd;
        3'd3:    data_wr = data & ~wd;
        default: data_wr = data;
      endcase
    end
  end

  assign trigger = wr_en && (address == 3'd0 || address == 3'd2) && ((data_wr & mask) != '0);

  // Trigger beats everything; otherwise a pulse whose masked bits were cleared
  // by software ends quietly, and a normal expiry clears only the masked bits.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    data_next  = data_wr;
    if (trigger) begin
      state_next = COUNT;
      cnt_next   = plen;
    end else if (state == COUNT) begin
      if ((data & mask) == '0) begin
        state_next = IDLE;
      end else begin
        cnt_next = cnt - 16'd1;
        if (cnt == 16'd1) begin
          data_next  = data_wr & ~mask;
          state_next = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= RESET_VALUE;
      mask  <= '0;
      plen  <= 16'(DEFAULT_PULSE_LEN);
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      data  <= data_next;
      if (wr_en && address == 3'd1) begin
        mask <= wd;
      end
      if (wr_en && address == 3'd4) begin
        plen <= (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
      end
    end
  end

  assign busy     = (state == COUNT);
  assign out_port = data;

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = data;
      3'd1:    readdata[WIDTH-1:0] = mask;
      3'd4:    readdata[15:0]      = plen;
      3'd5:    readdata[0]         = busy;
      default: readdata            = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_pio_pulse_out.sv
// tb/tb_nios_pio_pulse_out.sv - directed self-checking bench for nios_pio_pulse_out
module tb_nios_pio_pulse_out;

  localparam int        WIDTH = 8;
  localparam logic [7:0] RV   = 8'h5A;
  localparam int        DPL   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        busy;

  int checks = 0;
  int passes = 0;

  nios_pio_pulse_out #(
    .WIDTH(WIDTH), .RESET_VALUE(RV), .DEFAULT_PULSE_LEN(DPL)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    step(); step();
    chk("reset_out", out_port, RV);
    chk("reset_busy", busy, 0);
    rd("reset_len", 3'd4, DPL);
    rd("reset_mask", 3'd1, 0);
    rd("reset_status", 3'd5, 0);
    reset = 1'b0;
    step();

    wr(3'd0, 32'h1A5);
    chk("data_write", out_port, 8'hA5);
    rd("data_read", 3'd0, 32'h0000_00A5);

    wr(3'd0, 32'hF0);
    wr(3'd2, 32'h0F);
    chk("outset", out_port, 8'hFF);
    wr(3'd3, 32'h81);
    chk("outclear", out_port, 8'h7E);
    rd("rd_outset", 3'd2, 0);
    rd("rd_outclear", 3'd3, 0);
    rd("rd_addr6", 3'd6, 0);
    wr(3'd7, 32'hFF);
    chk("wr_addr7", out_port, 8'h7E);

    address = 3'd0; writedata = 32'h00; chipselect = 1'b0; write_n = 1'b0;
    step();
    chipselect = 1'b1; write_n = 1'b1;
    step();
    chipselect = 1'b0;
    chk("unqualified", out_port, 8'h7E);

    // single pulse of 4 cycles
    wr(3'd0, 32'h80);
    wr(3'd1, 32'h01);
    wr(3'd4, 32'd4);
    rd("len_rd", 3'd4, 4);
    wr(3'd2, 32'h01);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pulse_hi%0d", i), out_port, 8'h81);
      chk($sformatf("pulse_busy%0d", i), busy, 1);
      step();
    end
    chk("pulse_end", out_port, 8'h80);
    chk("pulse_end_busy", busy, 0);

    // retrigger three cycles in: 8 cycles total
    wr(3'd4, 32'd5);
    wr(3'd2, 32'h01);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("retrig_a%0d", i), out_port, 8'h81);
      if (i < 2) step();
    end
    wr(3'd2, 32'h01);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("retrig_b%0d", i), out_port, 8'h81);
      step();
    end
    chk("retrig_end", out_port, 8'h80);
    chk("retrig_end_busy", busy, 0);

    // retrigger exactly on the expiry edge: no gap
    wr(3'd2, 32'h01);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("exp_a%0d", i), out_port, 8'h81);
      step();
    end
    wr(3'd2, 32'h01);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("exp_b%0d", i), out_port, 8'h81);
      chk($sformatf("exp_busy%0d", i), busy, 1);
      step();
    end
    chk("exp_end", out_port, 8'h80);

    // OUTCLEAR aborts a running pulse
    wr(3'd2, 32'h01);
    step();
    chk("abort_busy0", busy, 1);
    wr(3'd3, 32'h01);
    chk("abort_data", out_port, 8'h80);
    chk("abort_busy1", busy, 1);
    step();
    chk("abort_busy2", busy, 0);
    rd("abort_status", 3'd5, 0);
    wr(3'd4, 32'd0);
    rd("len_zero", 3'd4, 1);

    // mask change mid-pulse: expiry uses the current mask
    wr(3'd4, 32'd3);
    wr(3'd2, 32'h03);
    wr(3'd1, 32'h02);
    chk("mask_mid", out_port, 8'h83);
    step();
    chk("mask_mid_busy", busy, 1);
    step();
    chk("mask_exp", out_port, 8'h81);
    chk("mask_exp_busy", busy, 0);

    // reset mid-pulse with a simultaneous DATA write
    wr(3'd1, 32'h01);
    wr(3'd2, 32'h01);
    step();
    reset = 1'b1; address = 3'd0; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    chk("rst_out", out_port, RV);
    chk("rst_busy", busy, 0);
    rd("rst_len", 3'd4, DPL);
    reset = 1'b0;
    step(); step(); step();
    chk("rst_hold", out_port, RV);
    chk("rst_hold_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
